frame_stream_source: RTL and testbench
======================================

// Module: frame_stream_source
// PURPOSE
//  Frame-buffer reader that feeds the pattern-recognition pixel pipeline (convolution_filter et al.).
//  On a start pulse it reads IMG_WIDTH*IMG_HEIGHT pixels in raster order from a synchronous RAM and
//  emits them on a valid/ready stream with SOF/EOL/EOF tags. A 2-entry output FIFO absorbs RAM latency,
//  sustaining 1 pixel/clk under any backpressure.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line
//  IMG_HEIGHT  480  lines per frame
//  W           8    pixel width (bits)
//  ADDR_W      $clog2(IMG_WIDTH*IMG_HEIGHT)  RAM address width
// PORTS
//  clk      in   1       clock
//  rst_n    in   1       synchronous, active-low reset
//  start    in   1       1-cycle frame request; ignored while busy
//  busy     out  1       high from the cycle after accepted start until the cycle done is high (inclusive)
//  done     out  1       1-cycle pulse, the cycle after the last pixel handshake
//  rd_en    out  1       RAM read strobe
//  rd_addr  out  ADDR_W  RAM read address
//  rd_data  in   W       RAM data, valid exactly 1 cycle after rd_en
//  y_valid  out  1       stream valid
//  y_ready  in   1       stream ready (from downstream filter)
//  y_data   out  W       pixel
//  y_sof    out  1       tag: first pixel of frame (addr 0)
//  y_eol    out  1       tag: last pixel of a line (col == IMG_WIDTH-1)
//  y_eof    out  1       tag: last pixel of frame
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; busy, done, rd_en, y_valid, y_sof/eol/eof = 0; rd_addr, y_data = 0;
//   FIFO flushed; in-flight read discarded; counters cleared. Mid-frame reset aborts the frame with no done pulse.
//  FSM: IDLE --start--> FETCH --last addr issued--> DRAIN --last pixel accepted--> DONE --> IDLE.
//   DONE lasts exactly 1 cycle (done=1). start sampled only in IDLE.
//  Handshake: transfer when y_valid && y_ready. While y_valid=1 && y_ready=0, y_data and tags hold stable.
//   y_valid never drops without a transfer.
//  Read issue (FETCH only): rd_en = (occ + inflight - pop) < 2.
//   occ = FIFO occupancy (0..2); inflight = rd_en of previous cycle; pop = current handshake.
//  rd_addr increments by 1 after each rd_en and holds otherwise. Tags are computed from the issued address
//   and column/row counters, delayed 1 cycle alongside rd_data, and written into the FIFO with the pixel.
//  The FIFO never overflows; an overflow is a design error (bench asserts on it).
//  FIFO: 2 entries, registered output; y_valid = (occ != 0). A write and a pop in the same cycle are both honoured.
//  Latency: start sampled at edge E0 -> rd_en high after E0 -> rd_data captured at E2 -> y_valid high after E2.
//   With y_ready=1 constantly, pixels stream on consecutive cycles; the last handshake occurs at edge
//   E0 + 2 + N (N = IMG_WIDTH*IMG_HEIGHT); done=1 the following cycle.
//  Column counter wraps 0..IMG_WIDTH-1; row increments on wrap. No wrap beyond N-1: FETCH->DRAIN when addr N-1 issued.
//  A start arriving in the DONE cycle is ignored. The next start is accepted in IDLE, one cycle after DONE at the earliest.
// TESTING
//  1) IMG 4x3, RAM[i]=i+0x10, y_ready=1, start -> 12 consecutive pixels 0x10..0x1B; sof on first;
//     eol on 4th/8th/12th; eof on 12th; done 1 cycle after 12th transfer; rd_en never exceeds 12 pulses.
//  2) Same image, y_ready toggled pseudo-randomly (50%) -> identical pixel/tag sequence;
//     data stable while stalled; FIFO occupancy <= 2 (assert).
//  3) y_ready held 0 for 20 cycles after first y_valid -> exactly 2 RAM reads outstanding (occ=2),
//     then rd_en=0 until ready returns; no pixel lost or duplicated.
//  4) start pulsed again at pixel 5 -> ignored; exactly 12 pixels and one done.
//     Second start 1 cycle after done -> second full frame correct.
//  5) rst_n=0 for 1 cycle at pixel 6 -> all outputs 0 next cycle, no done.
//     New start -> frame restarts at addr 0 with sof.
//  6) Default 640x480, y_ready=1 -> 307200 pixels, 480 eol, one eof; done at start edge + 307203.

Source files
------------

// File: rtl/frame_stream_source.sv
// Raster-order frame reader: RAM -> 2-entry FIFO -> valid/ready pixel stream tagged SOF/EOL/EOF.
// First pixel valid 2 cycles after start; reads throttle so occupancy plus in-flight never exceeds 2.
module frame_stream_source #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int W          = 8,
    parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [W-1:0]      rd_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [W-1:0]      y_data,
    output logic              y_sof,
    output logic              y_eol,
    output logic              y_eof
);

    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int EW = W + 3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]     LAST_ROW  = RW'(IMG_HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_inflight;
    logic              r_pend_sof;
    logic              r_pend_eol;
    logic              r_pend_eof;
    logic [1:0]        r_occ;
    logic [EW-1:0]     r_head;
    logic [EW-1:0]     r_tail;

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_level;
    logic              w_last_issue;
    logic              w_last_pop;
    logic              w_accept;
    logic [EW-1:0]     w_in;

    assign w_pop    = y_valid && y_ready;
    assign w_push   = r_inflight;
    assign w_accept = (r_state == S_IDLE) && start;

    // Entries the FIFO will have to hold next cycle if no new read is issued now.
    assign w_level  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign rd_en    = (r_state == S_FETCH) && (w_level < 3'd2);
    assign rd_addr  = r_addr;

    assign w_last_issue = rd_en && (r_addr == LAST_ADDR);
    assign w_last_pop   = w_pop && r_head[W+2];
    assign w_in         = {r_pend_eof, r_pend_eol, r_pend_sof, rd_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start)        r_state <= S_FETCH;
                S_FETCH: if (w_last_issue) r_state <= S_DRAIN;
                S_DRAIN: if (w_last_pop)   r_state <= S_DONE;
                default:                   r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (rd_en) begin
            r_addr <= r_addr + 1'b1;
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Tags ride one cycle behind the address so they meet rd_data at the FIFO input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_pend_sof <= 1'b0;
            r_pend_eol <= 1'b0;
            r_pend_eof <= 1'b0;
        end else begin
            r_inflight <= rd_en;
            if (rd_en) begin
                r_pend_sof <= (r_addr == '0);
                r_pend_eol <= (r_col == LAST_COL);
                r_pend_eof <= (r_col == LAST_COL) && (r_row == LAST_ROW);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_push) begin
                        r_head <= w_in;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({w_push, w_pop})
                        2'b11: r_head <= w_in;
                        2'b01: r_occ  <= 2'd0;
                        2'b10: begin
                            r_tail <= w_in;
                            r_occ  <= 2'd2;
                        end
                        default: r_occ <= 2'd1;
                    endcase
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) r_tail <= w_in;
                        else        r_occ  <= 2'd1;
                    end
                end
                default: r_occ <= 2'd0;
            endcase
        end
    end

    assign y_valid = (r_occ != 2'd0);
    assign y_data  = r_head[W-1:0];
    assign y_sof   = y_valid && r_head[W];
    assign y_eol   = y_valid && r_head[W+1];
    assign y_eof   = y_valid && r_head[W+2];

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source on a 4x3 image with RAM[i] = 0x10 + i.
module tb_frame_stream_source;

    localparam int IW = 4;
    localparam int IH = 3;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int N  = IW * IH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          y_ready;
    logic          busy, done, rd_en, y_valid, y_sof, y_eol, y_eof;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  y_data;

    logic [W-1:0]  mem [0:15];

    int checks = 0;
    int errors = 0;

    logic          clr;
    int            rd_cnt, pop_cnt, done_cnt, max_out, stall_err;
    logic [W+2:0]  q [$];
    logic          prev_stall;
    logic [W+2:0]  prev_word;
    logic [W+2:0]  w_word;
    logic          w_hs;

    frame_stream_source #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .W         (W),
        .ADDR_W    (AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .y_valid(y_valid),
        .y_ready(y_ready),
        .y_data (y_data),
        .y_sof  (y_sof),
        .y_eol  (y_eol),
        .y_eof  (y_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    assign w_word = {y_eof, y_eol, y_sof, y_data};
    assign w_hs   = y_valid && y_ready;

    // Observer on the falling edge, where every DUT input and output is settled.
    always @(negedge clk) begin
        if (clr) begin
            rd_cnt     <= 0;
            pop_cnt    <= 0;
            done_cnt   <= 0;
            max_out    <= 0;
            stall_err  <= 0;
            prev_stall <= 1'b0;
            q.delete();
        end else if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            rd_cnt  <= rd_cnt + int'(rd_en);
            pop_cnt <= pop_cnt + int'(w_hs);
            if ((rd_cnt + int'(rd_en)) - (pop_cnt + int'(w_hs)) > max_out)
                max_out <= (rd_cnt + int'(rd_en)) - (pop_cnt + int'(w_hs));
            if (w_hs) q.push_back(w_word);
            if (done) done_cnt <= done_cnt + 1;
            if (prev_stall && (!y_valid || w_word != prev_word))
                stall_err <= stall_err + 1;
            prev_stall <= y_valid && !y_ready;
            prev_word  <= w_word;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        clr   = 1'b1;
        start = 1'b1;
        step();
        clr   = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            ok = done;
        end
        chk({tag, " done timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_pops(input string tag, input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = (pop_cnt >= n);
        end
        chk({tag, " pop timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " busy"},    32'(busy),    32'd0);
        chk({tag, " done"},    32'(done),    32'd0);
        chk({tag, " rd_en"},   32'(rd_en),   32'd0);
        chk({tag, " y_valid"}, 32'(y_valid), 32'd0);
        chk({tag, " y_sof"},   32'(y_sof),   32'd0);
        chk({tag, " y_eol"},   32'(y_eol),   32'd0);
        chk({tag, " y_eof"},   32'(y_eof),   32'd0);
        chk({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, " y_data"},  32'(y_data),  32'd0);
    endtask

    task automatic check_frame(input string tag, input int exp_done);
        logic [W+2:0] exp_word;
        chk({tag, " pixel count"}, 32'(q.size()), 32'(N));
        for (int i = 0; i < N; i++) begin
            if (i < q.size()) begin
                exp_word = {(i == N - 1), (i % IW == IW - 1), (i == 0), W'(8'h10 + i)};
                chk($sformatf("%s px%0d", tag, i), 32'(q[i]), 32'(exp_word));
            end
        end
        chk({tag, " rd_en pulses"},  32'(rd_cnt),     32'(N));
        chk({tag, " done count"},    32'(done_cnt),   32'(exp_done));
        chk({tag, " stall stable"},  32'(stall_err),  32'd0);
        chk({tag, " occupancy<=2"},  32'(max_out <= 2), 32'd1);
    endtask

    initial begin
        logic seen_done;
        for (int i = 0; i < 16; i++) mem[i] = W'(8'h10 + i);
        rst_n   = 1'b0;
        start   = 1'b0;
        y_ready = 1'b1;
        clr     = 1'b1;
        repeat (3) step();
        clr = 1'b0;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // Test 1: full-rate frame with cycle-exact latency
        kick();
        chk("t1 busy k0",   32'(busy),    32'd1);
        chk("t1 rd_en k0",  32'(rd_en),   32'd1);
        chk("t1 addr k0",   32'(rd_addr), 32'd0);
        step();
        chk("t1 valid k1",  32'(y_valid), 32'd0);
        chk("t1 addr k1",   32'(rd_addr), 32'd1);
        step();
        chk("t1 valid k2",  32'(y_valid), 32'd1);
        chk("t1 sof k2",    32'(y_sof),   32'd1);
        chk("t1 data k2",   32'(y_data),  32'h10);
        repeat (11) step();
        chk("t1 done k13",  32'(done),    32'd0);
        step();
        chk("t1 done k14",  32'(done),    32'd1);
        chk("t1 busy k14",  32'(busy),    32'd1);
        step();
        chk("t1 done k15",  32'(done),    32'd0);
        chk("t1 busy k15",  32'(busy),    32'd0);
        check_frame("t1", 1);

        // Test 2: random backpressure
        kick();
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 300 && !ok; i++) begin
                y_ready = 1'($urandom_range(0, 1));
                step();
                ok = done;
            end
            chk("t2 done timeout", 32'(ok), 32'd1);
        end
        y_ready = 1'b1;
        check_frame("t2", 0);
        step();

        // Test 3: long stall right after first valid
        y_ready = 1'b0;
        kick();
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                step();
                ok = y_valid;
            end
            chk("t3 valid timeout", 32'(ok), 32'd1);
        end
        repeat (20) step();
        chk("t3 rd_en held",  32'(rd_en),   32'd0);
        chk("t3 reads",       32'(rd_cnt),  32'd2);
        chk("t3 pops",        32'(pop_cnt), 32'd0);
        chk("t3 valid held",  32'(y_valid), 32'd1);
        chk("t3 data held",   32'(y_data),  32'h10);
        y_ready = 1'b1;
        wait_done("t3");
        check_frame("t3", 0);
        step();

        // Test 4: start while busy, start in DONE, start right after
        kick();
        wait_pops("t4", 5);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t4a");
        check_frame("t4a", 0);
        kick();
        chk("t4 start in done", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4 restart busy",  32'(busy), 32'd1);
        wait_done("t4b");
        check_frame("t4b", 0);
        step();

        // Test 5: mid-frame reset aborts, next frame restarts cleanly
        kick();
        wait_pops("t5", 6);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_outputs_zero("t5 reset");
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen_done = seen_done | done;
        end
        chk("t5 no done", 32'(seen_done), 32'd0);
        chk("t5 idle",    32'(busy),      32'd0);
        kick();
        wait_done("t5");
        check_frame("t5", 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
